// File: rtl/hazard_pkg.sv
// Shared types and constants for the vector-pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline-side bundle: register addresses and stage controls in, hazard controls out.
interface hazard_controller_if #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] ra1D, ra2D, ra1E, ra2E;
  logic [REG_W-1:0] WA3E, WA3M, WA3W;
  logic             RegWriteM, RegWriteW, MemtoRegE;
  logic             MemReqM, MemAck;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             EN1, EN2, CLR2, HoldM, MemErr;
  logic [CNT_W-1:0] StallCount;

  modport master (
    output ra1D, ra2D, ra1E, ra2E, WA3E, WA3M, WA3W,
           RegWriteM, RegWriteW, MemtoRegE, MemReqM, MemAck,
    input  ForwardAE, ForwardBE, EN1, EN2, CLR2, HoldM, MemErr, StallCount
  );

  modport slave (
    input  ra1D, ra2D, ra1E, ra2E, WA3E, WA3M, WA3W,
           RegWriteM, RegWriteW, MemtoRegE, MemReqM, MemAck,
    output ForwardAE, ForwardBE, EN1, EN2, CLR2, HoldM, MemErr, StallCount
  );
endinterface

// File: rtl/hazard_controller_mem_wait_fsm.sv
// Multi-cycle memory access sequencer with timeout and sticky error.
module mem_wait_fsm
  import hazard_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic MemReqM,
  input  logic MemAck,
  output logic MemWait,
  output logic MemErr
);

  state_e          state_q;
  logic [TO_W-1:0] to_cnt_q;
  logic            err_q;

  // Hold drops in the cycle the ack is seen, so the pipe advances on that edge.
  assign MemWait = ((state_q == IDLE) && MemReqM && !MemAck) ||
                   ((state_q == WAIT) && !MemAck);
  assign MemErr  = err_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (MemReqM && !MemAck) begin
            state_q  <= WAIT;
            to_cnt_q <= TO_W'(1);
          end
        end
        WAIT: begin
          if (MemAck) begin
            state_q  <= IDLE;
            to_cnt_q <= '0;
          end else if (to_cnt_q == TO_W'(TIMEOUT)) begin
            state_q <= ERR;
            err_q   <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        ERR: begin
          state_q <= ERR;
          err_q   <= 1'b1;
        end
        default: begin
          state_q  <= IDLE;
          to_cnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Hazard control for the 5-stage vector pipe: forwarding, load-use stall, memory hold, stall counter.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int REG_W   = 4,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8,
  parameter int CNT_W   = 16
) (
  input  logic              CLK,
  input  logic              RST,
  hazard_controller_if.slave hz
);

  logic             mem_wait, mem_err, ld_stall;
  logic             en_d, clr_d, hold_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] ra);
    if (hz.RegWriteM && (hz.WA3M == ra))      return FWD_MEM;
    else if (hz.RegWriteW && (hz.WA3W == ra)) return FWD_WB;
    else                                      return FWD_RF;
  endfunction

  mem_wait_fsm #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_mem_wait_fsm (
    .CLK     (CLK),
    .RST     (RST),
    .MemReqM (hz.MemReqM),
    .MemAck  (hz.MemAck),
    .MemWait (mem_wait),
    .MemErr  (mem_err)
  );

  assign ld_stall = hz.MemtoRegE && ((hz.WA3E == hz.ra1D) || (hz.WA3E == hz.ra2D));

  // Freeze outranks bubble injection; a load-use stall resurfaces once the hold releases.
  always_comb begin
    en_d   = 1'b1;
    clr_d  = 1'b0;
    hold_d = 1'b0;
    if (!RST) begin
      en_d  = 1'b0;
      clr_d = 1'b1;
    end else if (mem_err || mem_wait) begin
      en_d   = 1'b0;
      hold_d = 1'b1;
    end else if (ld_stall) begin
      en_d  = 1'b0;
      clr_d = 1'b1;
    end
  end

  assign stall_cnt_d = (!en_d && (stall_cnt_q != {CNT_W{1'b1}})) ?
                       stall_cnt_q + CNT_W'(1) : stall_cnt_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign hz.ForwardAE  = RST ? fwd_sel(hz.ra1E) : FWD_RF;
  assign hz.ForwardBE  = RST ? fwd_sel(hz.ra2E) : FWD_RF;
  assign hz.EN1        = en_d;
  assign hz.EN2        = en_d;
  assign hz.CLR2       = clr_d;
  assign hz.HoldM      = hold_d;
  assign hz.MemErr     = mem_err;
  assign hz.StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller (TIMEOUT=4, CNT_W=3).
module tb_hazard_controller;
  import hazard_pkg::*;

  localparam int REG_W = 4;
  localparam int CNT_W = 3;

  typedef struct {
    string      nm;
    logic [12:0] v;  // {EN1,EN2,CLR2,HoldM,FAE[1:0],FBE[1:0],MemErr,StallCount[2:0]} padded
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  hazard_controller_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hz ();

  hazard_controller #(
    .REG_W   (REG_W),
    .TIMEOUT (4),
    .TO_W    (8),
    .CNT_W   (CNT_W)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .hz  (hz.slave)
  );

  always #5 CLK = ~CLK;

  function automatic logic [12:0] pack(input logic en, input logic clr, input logic hold,
                                       input logic [1:0] fa, input logic [1:0] fb,
                                       input logic err, input int cnt);
    return {1'b0, en, en, clr, hold, fa, fb, err, 3'(cnt)};
  endfunction

  // Monitor: compares each queued expectation against the DUT away from the active edge.
  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [12:0] act;
      e   = sb.pop_front();
      act = {1'b0, hz.EN1, hz.EN2, hz.CLR2, hz.HoldM, hz.ForwardAE, hz.ForwardBE,
             hz.MemErr, hz.StallCount};
      n_tests++;
      if (act !== e.v) begin
        n_fail++;
        $display("FAIL %s: got EN1/EN2/CLR2/Hold=%b FAE=%b FBE=%b Err=%b Cnt=%0d, want %b FAE=%b FBE=%b Err=%b Cnt=%0d",
                 e.nm, act[11:8], act[7:6], act[5:4], act[3], act[2:0],
                 e.v[11:8], e.v[7:6], e.v[5:4], e.v[3], e.v[2:0]);
      end
    end
  end

  task automatic cyc(input string nm, input logic [12:0] v);
    exp_t e;
    e.nm = nm;
    e.v  = v;
    sb.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic clr_inputs();
    hz.ra1D = '0; hz.ra2D = '0; hz.ra1E = '0; hz.ra2E = '0;
    hz.WA3E = '0; hz.WA3M = '0; hz.WA3W = '0;
    hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0; hz.MemtoRegE = 1'b0;
    hz.MemReqM = 1'b0; hz.MemAck = 1'b0;
  endtask

  task automatic do_reset(input string nm);
    RST = 1'b0;
    cyc(nm, pack(1'b0, 1'b1, 1'b0, FWD_RF, FWD_RF, 1'b0, 0));
    RST = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_inputs();
    @(posedge CLK);
    #1;
    do_reset("reset_state");

    cyc("idle0", pack(1, 0, 0, FWD_RF, FWD_RF, 0, 0));
    cyc("idle1", pack(1, 0, 0, FWD_RF, FWD_RF, 0, 0));

    // Forwarding
    hz.ra1E = 4'd3; hz.WA3M = 4'd3; hz.RegWriteM = 1; hz.WA3W = 4'd3; hz.RegWriteW = 1; hz.ra2E = 4'd5;
    cyc("fwd_mem_prio", pack(1, 0, 0, FWD_MEM, FWD_RF, 0, 0));
    hz.RegWriteM = 0;
    cyc("fwd_wb", pack(1, 0, 0, FWD_WB, FWD_RF, 0, 0));
    hz.WA3W = 4'd5;
    cyc("fwd_b_wb", pack(1, 0, 0, FWD_RF, FWD_WB, 0, 0));
    hz.RegWriteM = 1; hz.WA3M = 4'd5;
    cyc("fwd_b_mem", pack(1, 0, 0, FWD_RF, FWD_MEM, 0, 0));
    hz.ra1E = 4'd0; hz.WA3M = 4'd0; hz.ra2E = 4'd15; hz.WA3W = 4'd15;
    cyc("fwd_reg0_and_15", pack(1, 0, 0, FWD_MEM, FWD_WB, 0, 0));
    clr_inputs();

    // Load-use
    hz.MemtoRegE = 1; hz.WA3E = 4'd7; hz.ra2D = 4'd7; hz.ra1D = 4'd1;
    cyc("lduse_ra2", pack(0, 1, 0, FWD_RF, FWD_RF, 0, 0));
    hz.MemtoRegE = 0;
    cyc("lduse_after", pack(1, 0, 0, FWD_RF, FWD_RF, 0, 1));
    hz.MemtoRegE = 1; hz.WA3E = 4'd2; hz.ra1D = 4'd2;
    cyc("lduse_ra1", pack(0, 1, 0, FWD_RF, FWD_RF, 0, 1));
    hz.WA3E = 4'd9;
    cyc("lduse_nomatch", pack(1, 0, 0, FWD_RF, FWD_RF, 0, 2));
    clr_inputs();

    // Memory wait: ack on the 4th cycle -> 3 hold cycles
    do_reset("reset_before_wait");
    hz.MemReqM = 1;
    cyc("wait_c1", pack(0, 0, 1, FWD_RF, FWD_RF, 0, 0));
    cyc("wait_c2", pack(0, 0, 1, FWD_RF, FWD_RF, 0, 1));
    cyc("wait_c3", pack(0, 0, 1, FWD_RF, FWD_RF, 0, 2));
    hz.MemAck = 1;
    cyc("wait_ack", pack(1, 0, 0, FWD_RF, FWD_RF, 0, 3));
    cyc("single_cycle_acc", pack(1, 0, 0, FWD_RF, FWD_RF, 0, 3));
    hz.MemReqM = 0;
    cyc("stray_ack", pack(1, 0, 0, FWD_RF, FWD_RF, 0, 3));
    hz.MemAck = 0;
    cyc("back_idle", pack(1, 0, 0, FWD_RF, FWD_RF, 0, 3));

    // Timeout -> ERR, sticky, then async reset mid-cycle
    do_reset("reset_before_to");
    hz.MemReqM = 1;
    for (int i = 0; i < 6; i++)
      cyc($sformatf("to_c%0d", i), pack(0, 0, 1, FWD_RF, FWD_RF, i >= 5, i));
    hz.MemReqM = 0;
    cyc("err_sticky", pack(0, 0, 1, FWD_RF, FWD_RF, 1, 6));
    hz.MemAck = 1;
    cyc("err_ignores_ack", pack(0, 0, 1, FWD_RF, FWD_RF, 1, 7));
    cyc("cnt_saturated", pack(0, 0, 1, FWD_RF, FWD_RF, 1, 7));
    clr_inputs();
    do_reset("async_reset_from_err");
    cyc("after_err_reset", pack(1, 0, 0, FWD_RF, FWD_RF, 0, 0));

    // Priority: load-use concurrent with memory hold, run to saturation
    hz.MemReqM = 1; hz.MemtoRegE = 1; hz.WA3E = 4'd7; hz.ra2D = 4'd7;
    for (int i = 0; i < 10; i++)
      cyc($sformatf("prio_c%0d", i), pack(0, 0, 1, FWD_RF, FWD_RF, i >= 5, (i > 7) ? 7 : i));

    // Pending load-use re-evaluated once the hold releases
    do_reset("reset_before_release");
    cyc("rel_hold", pack(0, 0, 1, FWD_RF, FWD_RF, 0, 0));
    hz.MemAck = 1;
    cyc("rel_ldstall", pack(0, 1, 0, FWD_RF, FWD_RF, 0, 1));
    clr_inputs();
    cyc("rel_run", pack(1, 0, 0, FWD_RF, FWD_RF, 0, 2));

    @(posedge CLK);
    #1;
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
